// File: rtl/vector_fetch_sequencer.sv
// vector_fetch_sequencer
//
// Fetches the two-byte RESET/NMI/BRK/IRQ vector from the top page of memory
// and hands it to the program counter as a low/high byte pair with a
// one-cycle load strobe. PC increment is held off from the grant edge until
// the sequence returns to IDLE.
//
// Ports:
//   clk, reset   - rising-edge clock, asynchronous active-high reset
//   nmi          - NMI request, rising-edge sensitive
//   irq          - IRQ request, level sensitive, masked by irq_disable
//   brk_req      - one-cycle pulse from the decoder when BRK executes
//   irq_disable  - I flag, masks irq only
//   bus_ready    - data_in is valid this cycle
//   data_in      - memory read data
//   addr_out     - read address (held while bus_read is low)
//   bus_read     - read request
//   PCL_in/PCH_in- vector bytes to the PC (held until the next capture)
//   load         - one-cycle PC load strobe
//   inc_enable   - PC increment enable (high only in IDLE)
//   set_i_flag   - one-cycle pulse with load for every cause except RESET
//   busy         - a sequence is in progress
//   cause        - 0 RESET, 1 NMI, 2 BRK, 3 IRQ
module vector_fetch_sequencer #(
  parameter logic [7:0] VECTOR_PAGE = 8'hFF,
  parameter logic [7:0] NMI_VEC_LO  = 8'hFA,
  parameter logic [7:0] RST_VEC_LO  = 8'hFC,
  parameter logic [7:0] IRQ_VEC_LO  = 8'hFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nmi,
  input  logic        irq,
  input  logic        brk_req,
  input  logic        irq_disable,
  input  logic        bus_ready,
  input  logic [7:0]  data_in,
  output logic [15:0] addr_out,
  output logic        bus_read,
  output logic [7:0]  PCL_in,
  output logic [7:0]  PCH_in,
  output logic        load,
  output logic        inc_enable,
  output logic        set_i_flag,
  output logic        busy,
  output logic [1:0]  cause
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FETCH_LO = 2'd1;
  localparam logic [1:0] FETCH_HI = 2'd2;
  localparam logic [1:0] LOAD     = 2'd3;

  localparam logic [1:0] CAUSE_RESET = 2'd0;
  localparam logic [1:0] CAUSE_NMI   = 2'd1;
  localparam logic [1:0] CAUSE_BRK   = 2'd2;
  localparam logic [1:0] CAUSE_IRQ   = 2'd3;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       rst_pend;
  logic       nmi_pend;
  logic       brk_pend;
  logic       nmi_prev;
  logic [7:0] vec_lo;

  logic       nmi_edge;
  logic       nmi_req;
  logic       brk_any;
  logic       irq_req;
  logic       grant;
  logic       grant_rst;
  logic       grant_nmi;
  logic       grant_brk;
  logic [1:0] grant_cause;
  logic [7:0] grant_vec;

  // Requests arriving on the grant edge itself are folded in, so an NMI edge
  // and a BRK pulse that coincide with a live IRQ still win priority.
  assign nmi_edge = nmi & ~nmi_prev;
  assign nmi_req  = nmi_pend | nmi_edge;
  assign brk_any  = brk_pend | brk_req;
  assign irq_req  = irq & ~irq_disable;

  // Priority arbiter, only active in IDLE.
  always_comb begin
    grant       = 1'b0;
    grant_rst   = 1'b0;
    grant_nmi   = 1'b0;
    grant_brk   = 1'b0;
    grant_cause = CAUSE_RESET;
    grant_vec   = RST_VEC_LO;
    if (state == IDLE) begin
      if (rst_pend) begin
        grant       = 1'b1;
        grant_rst   = 1'b1;
        grant_cause = CAUSE_RESET;
        grant_vec   = RST_VEC_LO;
      end else if (nmi_req) begin
        grant       = 1'b1;
        grant_nmi   = 1'b1;
        grant_cause = CAUSE_NMI;
        grant_vec   = NMI_VEC_LO;
      end else if (brk_any) begin
        grant       = 1'b1;
        grant_brk   = 1'b1;
        grant_cause = CAUSE_BRK;
        grant_vec   = IRQ_VEC_LO;
      end else if (irq_req) begin
        grant       = 1'b1;
        grant_cause = CAUSE_IRQ;
        grant_vec   = IRQ_VEC_LO;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (grant) next_state = FETCH_LO;
      FETCH_LO: if (bus_ready) next_state = FETCH_HI;
      FETCH_HI: if (bus_ready) next_state = LOAD;
      LOAD:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Control outputs are registered from next_state so that the reset values
  // (including inc_enable = 0) hold until the first clock after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rst_pend   <= 1'b1;
      nmi_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      nmi_prev   <= 1'b0;
      vec_lo     <= 8'h00;
      addr_out   <= 16'h0000;
      bus_read   <= 1'b0;
      PCL_in     <= 8'h00;
      PCH_in     <= 8'h00;
      load       <= 1'b0;
      set_i_flag <= 1'b0;
      busy       <= 1'b0;
      cause      <= CAUSE_RESET;
      inc_enable <= 1'b0;
    end else begin
      nmi_prev   <= nmi;
      rst_pend   <= rst_pend & ~grant_rst;
      nmi_pend   <= nmi_req & ~grant_nmi;
      brk_pend   <= brk_any & ~grant_brk;
      state      <= next_state;
      bus_read   <= (next_state == FETCH_LO) || (next_state == FETCH_HI);
      busy       <= (next_state != IDLE);
      inc_enable <= (next_state == IDLE);
      load       <= (next_state == LOAD);
      set_i_flag <= (next_state == LOAD) && (cause != CAUSE_RESET);
      case (state)
        IDLE: begin
          if (grant) begin
            cause    <= grant_cause;
            vec_lo   <= grant_vec;
            addr_out <= {VECTOR_PAGE, grant_vec};
          end
        end
        FETCH_LO: begin
          if (bus_ready) begin
            PCL_in   <= data_in;
            // High-byte address wraps within the vector page.
            addr_out <= {VECTOR_PAGE, vec_lo + 8'd1};
          end
        end
        FETCH_HI: begin
          if (bus_ready) PCH_in <= data_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_fetch_sequencer.sv
// tb_vector_fetch_sequencer
//
// Self-checking bench for vector_fetch_sequencer. A small vector ROM answers
// reads on the top page; each load strobe is checked against an expected
// queue filled by the stimulus thread.
module tb_vector_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        nmi = 1'b0;
  logic        irq = 1'b0;
  logic        brk_req = 1'b0;
  logic        irq_disable = 1'b0;
  logic        bus_ready = 1'b1;
  logic [7:0]  data_in;
  logic [15:0] addr_out;
  logic        bus_read;
  logic [7:0]  PCL_in;
  logic [7:0]  PCH_in;
  logic        load;
  logic        inc_enable;
  logic        set_i_flag;
  logic        busy;
  logic [1:0]  cause;

  int checks = 0;
  int errors = 0;
  int loStall = 0;
  int hiStall = 0;

  logic [7:0]  vecMem [0:7];
  logic [18:0] expQ [$];   // {PCH, PCL, cause, set_i_flag}

  vector_fetch_sequencer dut (
    .clk(clk), .reset(reset), .nmi(nmi), .irq(irq), .brk_req(brk_req),
    .irq_disable(irq_disable), .bus_ready(bus_ready), .data_in(data_in),
    .addr_out(addr_out), .bus_read(bus_read), .PCL_in(PCL_in), .PCH_in(PCH_in),
    .load(load), .inc_enable(inc_enable), .set_i_flag(set_i_flag),
    .busy(busy), .cause(cause)
  );

  always #5 clk = ~clk;

  // Vector ROM: only the top page returns vector bytes.
  always_comb begin
    data_in = 8'hEE;
    if (addr_out[15:8] == 8'hFF) data_in = vecMem[addr_out[2:0]];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string name);
    checkOutput(name, {25'd0, addr_out, bus_read, PCL_in, PCH_in, load, set_i_flag, busy, cause, inc_enable}, 64'd0);
  endtask

  task automatic pushExp(input logic [7:0] pch, input logic [7:0] pcl, input logic [1:0] c, input logic si);
    expQ.push_back({pch, pcl, c, si});
  endtask

  // Counts negedges from now until load, plus cycles spent reading each address.
  task automatic measure(output int lat, output int nLo, output int nHi);
    lat = 0; nLo = 0; nHi = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (bus_read && addr_out == 16'hFFFC) nLo++;
      if (bus_read && addr_out == 16'hFFFD) nHi++;
      if (load) break;
    end
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_drain"}, expQ.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic waitFor(input string name, input logic [1:0] c, input logic [15:0] a, input logic anyAddr);
    int n = 0;
    while (!(busy && cause == c && bus_read && (anyAddr || addr_out == a)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_timeout"}, (n >= 100), 0);
  endtask

  // Wait-state generator for the vector reads.
  initial begin
    forever begin
      @(negedge clk);
      bus_ready = 1'b1;
      if (bus_read && addr_out == 16'hFFFC && loStall > 0) begin
        bus_ready = 1'b0;
        loStall--;
      end else if (bus_read && addr_out == 16'hFFFD && hiStall > 0) begin
        bus_ready = 1'b0;
        hiStall--;
      end
    end
  end

  // Scoreboard monitor: every load strobe must match the oldest expectation.
  initial begin
    logic [18:0] e;
    forever begin
      @(negedge clk);
      if (set_i_flag && !load) checkOutput("set_i_without_load", set_i_flag, 0);
      if (load) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_load", {PCH_in, PCL_in, cause}, 0);
          errors += (({PCH_in, PCL_in, cause}) == 0) ? 1 : 0;
        end else begin
          e = expQ.pop_front();
          checkOutput("load_vector", {PCH_in, PCL_in, cause, set_i_flag, inc_enable, bus_read}, {e, 2'b00});
        end
      end
    end
  end

  task automatic applyStimulus();
    int lat, nLo, nHi, bad;

    // Power-up reset, zero wait states.
    #1 checkResetValues("reset_values");
    repeat (2) @(negedge clk);
    pushExp(8'h80, 8'h00, 2'd0, 1'b0);
    reset = 1'b0;
    measure(lat, nLo, nHi);
    checkOutput("rst_latency", lat, 3);
    checkOutput("rst_addr_cycles", {nLo[7:0], nHi[7:0]}, {8'd1, 8'd1});
    repeat (2) @(negedge clk);
    checkOutput("idle_after_rst", {inc_enable, busy, bus_read}, 3'b100);

    // RESET with 3 + 2 wait states.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    loStall = 3;
    hiStall = 2;
    pushExp(8'h80, 8'h00, 2'd0, 1'b0);
    reset = 1'b0;
    measure(lat, nLo, nHi);
    checkOutput("wait_latency", lat, 8);
    checkOutput("wait_addr_cycles", {nLo[7:0], nHi[7:0]}, {8'd4, 8'd3});
    waitDrain("wait");

    // NMI edge, BRK and IRQ together: NMI, then BRK, then IRQ.
    pushExp(8'h12, 8'h34, 2'd1, 1'b1);
    pushExp(8'h56, 8'h78, 2'd2, 1'b1);
    pushExp(8'h56, 8'h78, 2'd3, 1'b1);
    nmi = 1'b1; brk_req = 1'b1; irq = 1'b1;
    @(negedge clk);
    brk_req = 1'b0;
    checkOutput("prio_first_cause", {busy, cause}, {1'b1, 2'd1});
    nmi = 1'b0;
    waitFor("prio_irq", 2'd3, 16'h0, 1'b1);
    irq = 1'b0;
    waitDrain("prio");

    // Masked IRQ stays quiet, then starts once unmasked.
    irq_disable = 1'b1;
    irq = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || bus_read) bad++;
    end
    checkOutput("mask_quiet", bad, 0);
    pushExp(8'h56, 8'h78, 2'd3, 1'b1);
    irq_disable = 1'b0;
    @(negedge clk);
    checkOutput("unmask_start", {bus_read, addr_out, cause}, {1'b1, 16'hFFFE, 2'd3});
    irq = 1'b0;
    waitDrain("unmask");

    // NMI edge during FETCH_HI of an IRQ; held level gives one NMI only.
    pushExp(8'h56, 8'h78, 2'd3, 1'b1);
    pushExp(8'h12, 8'h34, 2'd1, 1'b1);
    irq = 1'b1;
    waitFor("irq_fetch_hi", 2'd3, 16'hFFFF, 1'b0);
    nmi = 1'b1;
    irq = 1'b0;
    waitDrain("nmi_in_seq");
    repeat (20) @(negedge clk);
    nmi = 1'b0;

    // Reset in FETCH_HI of an IRQ: async clear, then a fresh RESET sequence.
    irq = 1'b1;
    waitFor("irq_fetch_hi2", 2'd3, 16'hFFFF, 1'b0);
    #2 reset = 1'b1;
    #1 checkResetValues("async_reset_values");
    irq = 1'b0;
    repeat (2) @(negedge clk);
    pushExp(8'h80, 8'h00, 2'd0, 1'b0);
    reset = 1'b0;
    waitDrain("reset_mid");
    repeat (20) @(negedge clk);
    checkOutput("final_queue", expQ.size(), 0);
  endtask

  initial begin
    vecMem[0] = 8'h00; vecMem[1] = 8'h00;
    vecMem[2] = 8'h34; vecMem[3] = 8'h12;
    vecMem[4] = 8'h00; vecMem[5] = 8'h80;
    vecMem[6] = 8'h78; vecMem[7] = 8'h56;
    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_fetch_sequencer.md
Name: vector_fetch_sequencer

Overview:
- Drives the PC load interface. It supplies the 16-bit value and load strobe that the program counter consumes, and it holds PC increment off while it works.
- On reset, NMI, BRK or IRQ it reads the two-byte vector from the top page of memory over the CPU read bus. It then presents the result as low/high bytes with a one-cycle load strobe.
- It sits between the interrupt inputs, the memory read port and the program counter.

Parameters:
- VECTOR_PAGE, 8'hFF, high byte of all vector addresses.
- NMI_VEC_LO, 8'hFA, low byte of the NMI vector address. Low byte + 1 is the high-byte address.
- RST_VEC_LO, 8'hFC, low byte of the RESET vector address.
- IRQ_VEC_LO, 8'hFE, low byte of the IRQ/BRK vector address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- nmi  in  1  NMI request, rising-edge sensitive.
- irq  in  1  IRQ request, level sensitive.
- brk_req  in  1  single-cycle pulse from the decoder when BRK executes.
- irq_disable  in  1  I flag; masks irq only.
- bus_ready  in  1  memory has valid data_in this cycle.
- data_in  in  8  memory read data.
- addr_out  out  16  read address.
- bus_read  out  1  read request.
- PCL_in  out  8  low byte of the vector, to the PC.
- PCH_in  out  8  high byte of the vector, to the PC.
- load  out  1  PC load strobe.
- inc_enable  out  1  PC increment enable.
- set_i_flag  out  1  one-cycle pulse to set the I flag.
- busy  out  1  a sequence is in progress.
- cause  out  2  source being serviced: 0 RESET, 1 NMI, 2 BRK, 3 IRQ.

Behaviour:
- Reset (asynchronous, active-high) forces these values:
  - state = IDLE, rst_pend = 1, nmi_pend = 0, brk_pend = 0, nmi_prev = 0.
  - Outputs: addr_out = 0, bus_read = 0, PCL_in = 0, PCH_in = 0, load = 0, set_i_flag = 0, busy = 0, cause = 0, inc_enable = 0.
- Reset asserted mid-sequence abandons that sequence. After reset deasserts, a RESET sequence always runs first.
- NMI edge detect: nmi_pend is set on any clock where nmi = 1 and nmi_prev = 0. This applies in every state, so edges are never lost while busy.
- brk_pend is set on any clock where brk_req = 1.
- The IRQ line is not latched. It is sampled only in IDLE, and only when irq_disable = 0.
- Grant priority, evaluated in IDLE: rst_pend > nmi_pend > brk_pend > (irq & ~irq_disable).
  - The winner's pending bit clears on the grant edge.
  - cause and the vector low byte are registered on the grant edge.
- States and transitions:
  - IDLE: inc_enable = 1, busy = 0, bus_read = 0. If any grant is eligible, go to FETCH_LO; otherwise stay.
  - FETCH_LO: addr_out = {VECTOR_PAGE, vec_lo}, bus_read = 1, busy = 1, inc_enable = 0. On a clock edge with bus_ready = 1, capture data_in into PCL_in and go to FETCH_HI. Otherwise hold; wait states are unbounded.
  - FETCH_HI: addr_out = {VECTOR_PAGE, vec_lo + 1} (8-bit add, no carry into the page), bus_read = 1. On a clock edge with bus_ready = 1, capture data_in into PCH_in and go to LOAD.
  - LOAD: load = 1 for exactly one cycle, bus_read = 0, inc_enable = 0, PCL_in/PCH_in stable. set_i_flag = 1 for every cause except RESET. Next state is IDLE.
- Latency with zero wait states: grant edge plus 3 cycles, so load is high in the 3rd cycle after leaving IDLE.
- PCL_in and PCH_in hold their values after LOAD until the next capture.
- inc_enable is 0 from the grant edge through LOAD and returns to 1 in IDLE. The PC therefore never increments and loads in the same cycle.
- Back-to-back requests: a request pending at LOAD is granted in the following IDLE cycle. At least one IDLE cycle with inc_enable = 1 lies between sequences.
- bus_ready during IDLE or LOAD is ignored.
- addr_out holds its last value when bus_read = 0.

Test Plan:
- Power-up: assert reset for 2 cycles, release; memory FFFC = 8'h00, FFFD = 8'h80, bus_ready tied 1 → addr_out FFFC then FFFD; load pulses once with PCH_in/PCL_in = 80/00; cause = 0; set_i_flag stays 0; inc_enable = 1 afterward.
- Wait states: RESET sequence with bus_ready low for 3 cycles in FETCH_LO and 2 cycles in FETCH_HI → addr_out held at FFFC then FFFD during the stalls; load arrives 5 cycles later than in the zero-wait case; PCL_in/PCH_in correct.
- Priority: in IDLE, raise nmi edge, brk_req and irq together; FFFA/FFFB = 34/12, FFFE/FFFF = 78/56 → first load gives 12/34 with cause = 1; second gives 56/78 with cause = 2; third gives 56/78 with cause = 3; each with set_i_flag = 1.
- Masking: irq = 1 with irq_disable = 1 for 20 cycles → no bus_read, busy = 0. Clear irq_disable → IRQ sequence starts the next cycle.
- NMI during a sequence: nmi edge during FETCH_HI of an IRQ → IRQ completes; NMI is serviced in the following sequence. A held nmi level with no new edge → only one NMI sequence.
- Reset mid-sequence: assert reset in FETCH_HI → outputs go to reset values immediately (asynchronously); after release a full RESET sequence runs and the interrupted cause is not resumed.
